// File: rtl/ex_stage_if.sv
//------------------------------------------------------------------------------
// Module : ex_stage_if
// Brief  : Decode-to-execute operand bundle and execute-to-memory result bundle
//          for the ex_stage pipeline block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  // Decode side: drives operands, observes results and stall
  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o
  );

  // Execute side
  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, stallreq_o
  );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// Module : ex_stage
// Brief  : Execute stage. Logic, shift and add/sub results are registered with
//          one cycle of latency. Optional multi-cycle unsigned divider.
// Config : define EX_DIV_EN to compile in the DIVU divider; without it DIVU is
//          an unrecognised operation and stallreq_o is tied low.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  // Operation encodings shared with the decode stage
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  logic [31:0] alu_res;
  logic        alu_valid;
  logic [4:0]  shamt;

  assign shamt = bus.reg1_i[4:0];

  // Single-cycle result selection; anything not decoded yields 0 / invalid
  always_comb begin
    alu_res   = 32'h0;
    alu_valid = 1'b0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OR_OP:  begin alu_res = bus.reg1_i | bus.reg2_i;    alu_valid = 1'b1; end
          EXE_AND_OP: begin alu_res = bus.reg1_i & bus.reg2_i;    alu_valid = 1'b1; end
          EXE_XOR_OP: begin alu_res = bus.reg1_i ^ bus.reg2_i;    alu_valid = 1'b1; end
          EXE_NOR_OP: begin alu_res = ~(bus.reg1_i | bus.reg2_i); alu_valid = 1'b1; end
          default:    ;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_SLL_OP: begin alu_res = bus.reg2_i << shamt;                     alu_valid = 1'b1; end
          EXE_SRL_OP: begin alu_res = bus.reg2_i >> shamt;                     alu_valid = 1'b1; end
          EXE_SRA_OP: begin alu_res = 32'($signed(bus.reg2_i) >>> shamt);     alu_valid = 1'b1; end
          default:    ;
        endcase
      end
      EXE_RES_ARITH: begin
        case (bus.aluop_i)
          EXE_ADDU_OP: begin alu_res = bus.reg1_i + bus.reg2_i; alu_valid = 1'b1; end
          EXE_SUBU_OP: begin alu_res = bus.reg1_i - bus.reg2_i; alu_valid = 1'b1; end
          default:     ;
        endcase
      end
      default: ;
    endcase
`ifdef EX_DIV_EN
    // Divide by zero never enters the divider; it completes like a plain op
    if (bus.aluop_i == EXE_DIVU_OP && bus.reg2_i == 32'h0) begin
      alu_res   = 32'hFFFF_FFFF;
      alu_valid = 1'b1;
    end
`endif
  end

`ifdef EX_DIV_EN

  typedef enum logic [0:0] {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  div_state_t  state;
  logic [4:0]  cnt;
  // First BUSY cycle only arms the datapath; quotient bits follow on the next 32
  logic        prime;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  wd_l;
  logic        wreg_l;

  logic        div_start;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign div_start = (state == DIV_IDLE) && (bus.aluop_i == EXE_DIVU_OP) &&
                     (bus.reg2_i != 32'h0);

  // Restoring step: shift next dividend bit into the remainder and try subtract
  assign shifted  = {rem, quo[31]};
  assign trial    = shifted - {1'b0, dvs};
  assign q_bit    = ~trial[32];
  assign rem_next = q_bit ? trial[31:0] : shifted[31:0];
  assign quo_next = {quo[30:0], q_bit};

  assign bus.stallreq_o = ~rst & (div_start | ((state == DIV_BUSY) && (cnt != 5'd31)));

  // Divider FSM and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIV_IDLE;
      cnt         <= 5'd0;
      prime       <= 1'b0;
      rem         <= 32'h0;
      quo         <= 32'h0;
      dvs         <= 32'h0;
      wd_l        <= 5'd0;
      wreg_l      <= 1'b0;
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_start) begin
            state       <= DIV_BUSY;
            cnt         <= 5'd0;
            prime       <= 1'b1;
            rem         <= 32'h0;
            quo         <= bus.reg1_i;
            dvs         <= bus.reg2_i;
            wd_l        <= bus.wd_i;
            wreg_l      <= bus.wreg_i;
            bus.wd_o    <= 5'd0;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= 32'h0;
          end else begin
            bus.wd_o    <= bus.wd_i;
            bus.wreg_o  <= bus.wreg_i & alu_valid;
            bus.wdata_o <= alu_res;
          end
        end
        DIV_BUSY: begin
          bus.wd_o    <= 5'd0;
          bus.wreg_o  <= 1'b0;
          bus.wdata_o <= 32'h0;
          if (prime) begin
            prime <= 1'b0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == 5'd31) begin
              state       <= DIV_IDLE;
              cnt         <= 5'd0;
              bus.wd_o    <= wd_l;
              bus.wreg_o  <= wreg_l;
              bus.wdata_o <= quo_next;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

`else

  assign bus.stallreq_o = 1'b0;

  // One registered result per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wd_o    <= 5'd0;
      bus.wreg_o  <= 1'b0;
      bus.wdata_o <= 32'h0;
    end else begin
      bus.wd_o    <= bus.wd_i;
      bus.wreg_o  <= bus.wreg_i & alu_valid;
      bus.wdata_o <= alu_res;
    end
  end

`endif

endmodule

`default_nettype wire
